// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32 core: load-use stalls, taken-branch
// squash and data-memory wait, plus saturating stall/flush statistics.
module hazard_ctrl #(
    parameter int unsigned LU_BUBBLES   = 1,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_wb,
    input  logic             ex_is_load,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_hold,
    output logic             if_id_hold,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_hold,
    output logic             ex_mem_hold,
    output logic             mem_wb_bubble,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {StRun, StLuStall, StFlush} state_e;

    localparam logic [1:0] LuRem    = 2'(LU_BUBBLES - 1);
    localparam logic [1:0] FlushRem = 2'(FLUSH_CYCLES - 1);

    state_e           state_q, state_d;
    logic [1:0]       rem_q, rem_d;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             stall_inc, flush_inc;
    logic             load_use, mem_wait;

    assign load_use = ex_is_load & ex_reg_wb & (ex_rd != 5'd0) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
    assign mem_wait = mem_req & ~mem_ready;

    always_comb begin
        pc_hold       = 1'b0;
        if_id_hold    = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_stall   = 1'b0;
        id_ex_hold    = 1'b0;
        ex_mem_hold   = 1'b0;
        mem_wb_bubble = 1'b0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        state_d       = state_q;
        rem_d         = rem_q;
        if (reset) begin
            // controls stay low; registers are cleared in the sequential block
        end else if (mem_wait) begin
            // whole front of the pipe freezes; pending bubbles/flushes wait too
            pc_hold       = 1'b1;
            if_id_hold    = 1'b1;
            id_ex_hold    = 1'b1;
            ex_mem_hold   = 1'b1;
            mem_wb_bubble = 1'b1;
            stall_inc     = 1'b1;
        end else begin
            case (state_q)
                StFlush: begin
                    if_id_flush = 1'b1;
                    id_ex_stall = 1'b1;
                    rem_d       = rem_q - 2'd1;
                    if (rem_q == 2'd1) state_d = StRun;
                end
                StLuStall: begin
                    pc_hold     = 1'b1;
                    if_id_hold  = 1'b1;
                    id_ex_stall = 1'b1;
                    stall_inc   = 1'b1;
                    rem_d       = rem_q - 2'd1;
                    if (rem_q == 2'd1) state_d = StRun;
                end
                default: begin
                    if (ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_stall = 1'b1;
                        flush_inc   = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = StFlush;
                            rem_d   = FlushRem;
                        end
                    end else if (load_use) begin
                        pc_hold     = 1'b1;
                        if_id_hold  = 1'b1;
                        id_ex_stall = 1'b1;
                        stall_inc   = 1'b1;
                        if (LU_BUBBLES > 1) begin
                            state_d = StLuStall;
                            rem_d   = LuRem;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRun;
            rem_q   <= 2'd0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            if (stall_inc && stall_q != '1) stall_q <= stall_q + 1'b1;
            if (flush_inc && flush_q != '1) flush_q <= flush_q + 1'b1;
        end
    end

    assign stall_count = stall_q;
    assign flush_count = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl against a queue-based model of scheduled
// pipeline actions (LU_BUBBLES=2, FLUSH_CYCLES=3, CNT_W=4).
module tb_hazard_ctrl;

    localparam int unsigned LuB   = 2;
    localparam int unsigned FlC   = 3;
    localparam int unsigned CntW  = 4;
    localparam int          CntMax = (1 << CntW) - 1;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_uses_rs1, id_uses_rs2, ex_reg_wb, ex_is_load, ex_branch_taken;
    logic mem_req, mem_ready;
    logic pc_hold, if_id_hold, if_id_flush, id_ex_stall, id_ex_hold, ex_mem_hold, mem_wb_bubble;
    logic [CntW-1:0] stall_count, flush_count;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_ctrl #(.LU_BUBBLES(LuB), .FLUSH_CYCLES(FlC), .CNT_W(CntW)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_reg_wb(ex_reg_wb), .ex_is_load(ex_is_load),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_hold(id_ex_hold), .ex_mem_hold(ex_mem_hold),
        .mem_wb_bubble(mem_wb_bubble), .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: pending forced actions (0 = squash cycle, 1 = bubble cycle) in issue order
    bit   pend[$];
    int   m_stall, m_flush;
    logic [6:0] exp_ctl;

    localparam logic [6:0] CtlWait  = 7'b1100111; // pc,ifid_hold,ifid_flush,idex_stall,idex_hold,exmem,memwb
    localparam logic [6:0] CtlStall = 7'b1101000;
    localparam logic [6:0] CtlFlush = 7'b0011000;

    function automatic bit is_load_use();
        return ex_is_load && ex_reg_wb && ex_rd != 0 &&
               ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    endfunction

    function automatic int sat(input int v);
        return (v < CntMax) ? v + 1 : CntMax;
    endfunction

    task automatic randomize_inputs();
        reset           = ($urandom_range(0, 99) < 2);
        ex_rd           = 5'($urandom_range(0, 3));
        id_rs1          = 5'($urandom_range(0, 3));
        id_rs2          = 5'($urandom_range(0, 3));
        id_uses_rs1     = 1'($urandom);
        id_uses_rs2     = 1'($urandom);
        ex_reg_wb       = ($urandom_range(0, 3) != 0);
        ex_is_load      = 1'($urandom);
        ex_branch_taken = ($urandom_range(0, 99) < 15);
        mem_req         = ($urandom_range(0, 99) < 40);
        mem_ready       = ($urandom_range(0, 99) < 55);
    endtask

    initial begin
        reset = 1'b1;
        {id_rs1, id_rs2, ex_rd} = '0;
        {id_uses_rs1, id_uses_rs2, ex_reg_wb, ex_is_load, ex_branch_taken} = '0;
        mem_req = 1'b0;
        mem_ready = 1'b1;
        m_stall = 0;
        m_flush = 0;
        @(negedge clk);
        #1 check("reset_ctl", 32'({pc_hold, if_id_hold, if_id_flush, id_ex_stall, id_ex_hold,
                                   ex_mem_hold, mem_wb_bubble}), 32'd0);
        @(posedge clk);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            randomize_inputs();
            #1;
            exp_ctl = '0;
            if (!reset) begin
                if (mem_req && !mem_ready) begin
                    exp_ctl = CtlWait;
                end else if (pend.size() > 0) begin
                    exp_ctl = pend[0] ? CtlStall : CtlFlush;
                end else if (ex_branch_taken) begin
                    exp_ctl = CtlFlush;
                end else if (is_load_use()) begin
                    exp_ctl = CtlStall;
                end
            end
            check("ctl", 32'({pc_hold, if_id_hold, if_id_flush, id_ex_stall, id_ex_hold,
                              ex_mem_hold, mem_wb_bubble}), 32'(exp_ctl));
            check("stall_count", 32'(stall_count), 32'(m_stall));
            check("flush_count", 32'(flush_count), 32'(m_flush));

            // advance model by one clock
            if (reset) begin
                pend.delete();
                m_stall = 0;
                m_flush = 0;
            end else if (mem_req && !mem_ready) begin
                m_stall = sat(m_stall);
            end else if (pend.size() > 0) begin
                if (pend[0]) m_stall = sat(m_stall);
                void'(pend.pop_front());
            end else if (ex_branch_taken) begin
                m_flush = sat(m_flush);
                for (int k = 1; k < int'(FlC); k++) pend.push_back(1'b0);
            end else if (is_load_use()) begin
                m_stall = sat(m_stall);
                for (int k = 1; k < int'(LuB); k++) pend.push_back(1'b1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
